// File: rtl/apb_timer_slave.sv
// APB timer peripheral behind the AHB-to-APB bridge. It contains a small register
// file, a down-counter timer and a zero-wait-state APB protocol tracker.
//
// The state register trails the bus by one cycle:
//  - SETUP is entered on the edge that ends the bus setup phase.
//  - ACCESS is entered on the edge that ends the bus enable phase.
//  - Read data is presented during the ACCESS state.
//  - A write commits at the end of the ACCESS state, unless the bus keeps Penable
//    high into that cycle.
module apb_timer_slave #(
   parameter logic [31:0] ID_VALUE = 32'hA2B0_0001,
   parameter int unsigned CNT_W    = 32
) (
   input  logic        Hclk,
   input  logic        Hreset,
   input  logic        Psel,
   input  logic        Penable,
   input  logic        Pwrite,
   input  logic [31:0] Paddr,
   input  logic [31:0] Pwdata,
   output logic [31:0] Prdata,
   output logic        irq,
   output logic        prot_err
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned IDX_W  = 3;
   localparam int unsigned CTRL_W = 3;
   localparam int unsigned STAT_W = 2;
   localparam int unsigned WCNT_W = 16;

   localparam logic [IDX_W-1:0] REG_CTRL    = 3'd0;
   localparam logic [IDX_W-1:0] REG_LOAD    = 3'd1;
   localparam logic [IDX_W-1:0] REG_COUNT   = 3'd2;
   localparam logic [IDX_W-1:0] REG_STATUS  = 3'd3;
   localparam logic [IDX_W-1:0] REG_SCRATCH0 = 3'd4;
   localparam logic [IDX_W-1:0] REG_SCRATCH1 = 3'd5;
   localparam logic [IDX_W-1:0] REG_ID      = 3'd6;
   localparam logic [IDX_W-1:0] REG_WCNT    = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    addr_q, addr_d;
   logic                write_q, write_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   prdata_q, prdata_d;
   logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
   logic [CNT_W-1:0]    load_q, load_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [STAT_W-1:0]   status_q, status_d;
   logic [DATA_W-1:0]   scratch0_q, scratch0_d;
   logic [DATA_W-1:0]   scratch1_q, scratch1_d;
   logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
   logic                irq_q, irq_d;
   logic                perr_q, perr_d;

   // Bus phase decode and the setup-to-access consistency check.
   logic              bus_setup;
   logic              bus_access;
   logic              req_match;
   logic [IDX_W-1:0]  paddr_idx;
   logic              unused_paddr;

   assign paddr_idx    = Paddr[4:2];
   assign bus_setup    = Psel & ~Penable;
   assign bus_access   = Psel & Penable;
   assign req_match    = (paddr_idx == addr_q) && (Pwrite == write_q);
   assign unused_paddr = ^{Paddr[31:5], Paddr[1:0]};

   // FSM strobes, produced by the output process.
   logic latch_req;
   logic go_access;
   logic commit;
   logic perr_set;
   logic expire;
   logic [STAT_W-1:0] status_clr;
   logic [DATA_W-1:0] rd_mux;

   // FSM state register.
   always_ff @(posedge Hclk) begin
      if (Hreset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (bus_setup) state_d = ST_SETUP;
         end
         ST_SETUP: begin
            if (bus_access && req_match) state_d = ST_ACCESS;
            else if (bus_setup)          state_d = ST_SETUP;
            else                         state_d = ST_IDLE;
         end
         ST_ACCESS: begin
            if (bus_setup) state_d = ST_SETUP;
            else           state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: request latch, read capture, write commit and protocol error.
   always_comb begin
      latch_req = 1'b0;
      go_access = 1'b0;
      commit    = 1'b0;
      perr_set  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            latch_req = bus_setup;
            perr_set  = bus_access;
         end
         ST_SETUP: begin
            if (bus_access && req_match) begin
               go_access = 1'b1;
            end else begin
               perr_set  = 1'b1;
               latch_req = bus_setup;
            end
         end
         ST_ACCESS: begin
            latch_req = bus_setup;
            perr_set  = bus_access;
            commit    = write_q & ~bus_access;
         end
         default: ;
      endcase
   end

   // Read data multiplexer over the current register values.
   always_comb begin
      rd_mux = '0;
      case (addr_q)
         REG_CTRL:     rd_mux = DATA_W'(ctrl_q);
         REG_LOAD:     rd_mux = DATA_W'(load_q);
         REG_COUNT:    rd_mux = DATA_W'(count_q);
         REG_STATUS:   rd_mux = DATA_W'(status_q);
         REG_SCRATCH0: rd_mux = scratch0_q;
         REG_SCRATCH1: rd_mux = scratch1_q;
         REG_ID:       rd_mux = ID_VALUE;
         REG_WCNT:     rd_mux = DATA_W'(wcnt_q);
         default:      rd_mux = '0;
      endcase
   end

   // Request capture and read data register; Prdata is non-zero only during a read ACCESS.
   always_comb begin
      addr_d   = addr_q;
      write_d  = write_q;
      wdata_d  = wdata_q;
      prdata_d = '0;
      if (latch_req) begin
         addr_d  = paddr_idx;
         write_d = Pwrite;
      end
      if (go_access) begin
         wdata_d = Pwdata;
         if (!write_q) prdata_d = rd_mux;
      end
   end

   // Timer, register writes and status. Writes are applied after the timer so that they override it.
   always_comb begin
      ctrl_d     = ctrl_q;
      load_d     = load_q;
      count_d    = count_q;
      scratch0_d = scratch0_q;
      scratch1_d = scratch1_q;
      wcnt_d     = wcnt_q;
      status_clr = '0;
      expire     = 1'b0;

      if (ctrl_q[0]) begin
         if (count_q != '0) begin
            count_d = count_q - CNT_W'(1);
         end else begin
            expire = 1'b1;
            if (ctrl_q[2]) count_d   = load_q;
            else           ctrl_d[0] = 1'b0;
         end
      end

      if (commit) begin
         wcnt_d = wcnt_q + WCNT_W'(1);
         case (addr_q)
            REG_CTRL:     ctrl_d     = wdata_q[CTRL_W-1:0];
            REG_LOAD: begin
               load_d  = wdata_q[CNT_W-1:0];
               count_d = wdata_q[CNT_W-1:0];
            end
            REG_STATUS:   status_clr = wdata_q[STAT_W-1:0];
            REG_SCRATCH0: scratch0_d = wdata_q;
            REG_SCRATCH1: scratch1_d = wdata_q;
            default: ;
         endcase
      end

      // A hardware set in the same cycle as a W1C clear leaves the bit set.
      status_d = (status_q & ~status_clr) | {perr_set, expire};
      irq_d    = status_d[0] & ctrl_d[1];
      perr_d   = status_d[1];
   end

   // Datapath and register file flops.
   always_ff @(posedge Hclk) begin
      if (Hreset) begin
         addr_q     <= '0;
         write_q    <= 1'b0;
         wdata_q    <= '0;
         prdata_q   <= '0;
         ctrl_q     <= '0;
         load_q     <= '0;
         count_q    <= '0;
         status_q   <= '0;
         scratch0_q <= '0;
         scratch1_q <= '0;
         wcnt_q     <= '0;
         irq_q      <= 1'b0;
         perr_q     <= 1'b0;
      end else begin
         addr_q     <= addr_d;
         write_q    <= write_d;
         wdata_q    <= wdata_d;
         prdata_q   <= prdata_d;
         ctrl_q     <= ctrl_d;
         load_q     <= load_d;
         count_q    <= count_d;
         status_q   <= status_d;
         scratch0_q <= scratch0_d;
         scratch1_q <= scratch1_d;
         wcnt_q     <= wcnt_d;
         irq_q      <= irq_d;
         perr_q     <= perr_d;
      end
   end

   assign Prdata   = prdata_q;
   assign irq      = irq_q;
   assign prot_err = perr_q;

endmodule
